mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Control unit for the multicycle MIPS datapath: Moore FSM (main decoder) plus ALU decoder.
//  Sequences fetch/decode/execute for lw, sw, R-type, beq, addi, j.
//  Drives every datapath control input; takes op/funct from the instruction register and zero from the ALU.
// PARAMETERS
//  ILLEGAL_TRAP  0  0: unknown opcode -> FETCH (NOP); 1: unknown opcode -> HALT until reset
// PORTS
//  clk         in   1  clock, all state on rising edge
//  reset       in   1  synchronous, active-high
//  op          in   6  instr[31:26]
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag (combinational, same cycle)
//  pcen        out  1  PC register enable
//  irwrite     out  1  instruction register enable
//  memwrite    out  1  memory write strobe
//  regwrite    out  1  register file write enable
//  lord        out  1  address mux: 0=pc, 1=aluout
//  regdst      out  1  write reg: 0=rt, 1=rd
//  memtoreg    out  1  writeback: 0=aluout, 1=data
//  alusrca     out  1  0=pc, 1=A
//  alusrcb     out  2  00=B, 01=4, 10=signimm, 11=signimm<<2
//  pcsrc       out  2  00=aluresult, 01=aluout, 10=jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  state       out  4  current FSM state (debug)
//  halted      out  1  1 in HALT
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7
//          BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11 HALT=12; codes 13-15 -> FETCH next edge.
//  reset=1 at edge -> state=FETCH. While reset=1, pcen/irwrite/memwrite/regwrite forced 0; others per FETCH.
//  Transitions: FETCH->DECODE; DECODE by op: 100011/101011->MEMADR, 000000->RTYPEEX,
//   000100->BEQEX, 001000->ADDIEX, 000010->JEX, other->FETCH or HALT (ILLEGAL_TRAP).
//   MEMADR->MEMRD(lw)/MEMWR(sw); MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB;
//   MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH; HALT->HALT.
//  Outputs Moore-decoded from state; every unlisted output 0 (never X):
//   FETCH: alusrcb=01 aluop=00 irwrite pcwrite | DECODE: alusrcb=11 aluop=00
//   MEMADR/ADDIEX: alusrca=1 alusrcb=10 aluop=00 | MEMRD: lord=1 | MEMWR: lord=1 memwrite
//   MEMWB: memtoreg=1 regwrite | RTYPEEX: alusrca=1 alusrcb=00 aluop=10
//   RTYPEWB: regdst=1 regwrite | ADDIWB: regwrite | JEX: pcsrc=10 pcwrite
//   BEQEX: alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch
//  pcen = pcwrite | (branch & zero); only combinational path from input (zero) to output.
//  ALU decoder: aluop 00->010, 01->110, 10->funct: 100000->010, 100010->110, 100100->000,
//   100101->001, 101010->111, other->010; aluop 11 unused -> 010.
//  Latency (cycles): lw 5, sw 4, R 4, addi 4, beq 3, j 3; exactly one irwrite pulse per instruction.
//  op/funct sampled only in DECODE/MEMADR/RTYPEEX; IR stable since irwrite low outside FETCH.
//  Reset mid-instruction: abort, FETCH next cycle; no memwrite/regwrite on reset cycle.
// TESTING
//  reset 2 cycles -> state=0, pcen=irwrite=memwrite=regwrite=0; release -> pcen=irwrite=1, alusrcb=01.
//  op=100011 -> states 0,1,2,3,4,0; regwrite=1 memtoreg=1 only in state 4; lord=1 in state 3.
//  op=000100 zero=1 -> BEQEX pcen=1 pcsrc=01 alucontrol=110; zero=0 -> pcen=0, back to FETCH.
//  op=000000, funct sweep 20/22/24/25/2A hex -> alucontrol 010/110/000/001/111 in RTYPEEX; regdst=1 in RTYPEWB.
//  op=111111: ILLEGAL_TRAP=0 -> FETCH after DECODE; =1 -> HALT, halted=1, all enables 0 until reset.
//  reset during MEMWR (sw) -> memwrite=0 that cycle, state=FETCH next edge; then j: states 0,1,11 pcsrc=10 pcen=1.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore main decoder plus ALU decoder)
module mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       lord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       halted
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JEX = 4'd11, HALT = 4'd12
  } state_t;
  state_t cur, nxt, s;
  logic pcwrite, branch, iw, mw, rw;
  logic [1:0] aluop;
  assign state = cur;
  // state register
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
  // next-state decode; unused codes fall back to FETCH
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE:  nxt = (op == 6'b100011 || op == 6'b101011) ? MEMADR :
                     (op == 6'b000000) ? RTYPEEX :
                     (op == 6'b000100) ? BEQEX :
                     (op == 6'b001000) ? ADDIEX :
                     (op == 6'b000010) ? JEX :
                     ILLEGAL_TRAP ? HALT : FETCH;
      MEMADR:  nxt = (op == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  // Moore output decode; during reset outputs look like FETCH
  always_comb begin
    s = reset ? FETCH : cur;
    pcwrite = 1'b0;
    branch = 1'b0;
    iw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    lord = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop = 2'b00;
    halted = 1'b0;
    case (s)
      FETCH: begin
        alusrcb = 2'b01;
        iw = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   lord = 1'b1;
      MEMWR: begin
        lord = 1'b1;
        mw = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop = 2'b10;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        rw = 1'b1;
      end
      ADDIWB:  rw = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop = 2'b01;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end
  assign pcen = ~reset & (pcwrite | (branch & zero));
  assign irwrite = ~reset & iw;
  assign memwrite = ~reset & mw;
  assign regwrite = ~reset & rw;
  // ALU decoder
  always_comb
    alucontrol = (aluop == 2'b01) ? 3'b110 :
                 (aluop != 2'b10) ? 3'b010 :
                 (funct == 6'b100010) ? 3'b110 :
                 (funct == 6'b100100) ? 3'b000 :
                 (funct == 6'b100101) ? 3'b001 :
                 (funct == 6'b101010) ? 3'b111 : 3'b010;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus randomized check of mc_controller against a per-instruction state-path model
module tb_mc_controller;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic pcen, irwrite, memwrite, regwrite, lord, regdst, memtoreg, alusrca, halted;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic pcen_t, irwrite_t, memwrite_t, regwrite_t, lord_t, regdst_t, memtoreg_t, alusrca_t, halted_t;
  logic [1:0] alusrcb_t, pcsrc_t;
  logic [2:0] alucontrol_t;
  logic [3:0] state_t;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mc_controller #(.ILLEGAL_TRAP(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .lord(lord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state), .halted(halted));
  mc_controller #(.ILLEGAL_TRAP(1'b1)) dut_t (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen_t), .irwrite(irwrite_t), .memwrite(memwrite_t), .regwrite(regwrite_t),
    .lord(lord_t), .regdst(regdst_t), .memtoreg(memtoreg_t), .alusrca(alusrca_t),
    .alusrcb(alusrcb_t), .pcsrc(pcsrc_t), .alucontrol(alucontrol_t), .state(state_t), .halted(halted_t));
  wire [15:0] obs = {pcen, irwrite, memwrite, regwrite, lord, regdst, memtoreg, alusrca,
                     alusrcb, pcsrc, alucontrol, halted};
  wire [15:0] obs_t = {pcen_t, irwrite_t, memwrite_t, regwrite_t, lord_t, regdst_t, memtoreg_t,
                       alusrca_t, alusrcb_t, pcsrc_t, alucontrol_t, halted_t};
  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic logic [2:0] alu_of(input logic [5:0] f);
    logic [5:0] fs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [2:0] cs [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    foreach (fs[i]) if (f == fs[i]) return cs[i];
    return 3'b010;
  endfunction
  // expected control word per state, as full literal vectors:
  // {pcen irwrite memwrite regwrite lord regdst memtoreg alusrca, alusrcb, pcsrc, alucontrol, halted}
  function automatic logic [15:0] ev(input int s, input logic [5:0] f, input logic z);
    case (s)
      0:       return {8'b1100_0000, 2'b01, 2'b00, 3'b010, 1'b0};
      1:       return {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
      2, 9:    return {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
      3:       return {8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0};
      4:       return {8'b0001_0010, 2'b00, 2'b00, 3'b010, 1'b0};
      5:       return {8'b0010_1000, 2'b00, 2'b00, 3'b010, 1'b0};
      6:       return {8'b0000_0001, 2'b00, 2'b00, alu_of(f), 1'b0};
      7:       return {8'b0001_0100, 2'b00, 2'b00, 3'b010, 1'b0};
      8:       return {z, 7'b000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
      10:      return {8'b0001_0000, 2'b00, 2'b00, 3'b010, 1'b0};
      11:      return {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};
      default: return {8'b0000_0000, 2'b00, 2'b00, 3'b010, 1'b1};
    endcase
  endfunction
  // one instruction from FETCH; zmode<0 randomizes zero; abort>=0 asserts reset at that step
  task automatic run(input logic [5:0] o, input logic [5:0] f, input int zmode, input int abort);
    int seq[$];
    case (o)
      6'h23:   seq = '{0, 1, 2, 3, 4};
      6'h2b:   seq = '{0, 1, 2, 5};
      6'h00:   seq = '{0, 1, 6, 7};
      6'h04:   seq = '{0, 1, 8};
      6'h08:   seq = '{0, 1, 9, 10};
      6'h02:   seq = '{0, 1, 11};
      default: seq = '{0, 1};
    endcase
    op = o;
    funct = f;
    foreach (seq[i]) begin
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      if (i == abort) reset = 1'b1;
      @(negedge clk);
      chk("state", 16'(state), 16'(seq[i]));
      chk(i == abort ? "abort_out" : "out", obs, i == abort ? ev(0, f, zero) & 16'h0fff : ev(seq[i], f, zero));
      @(posedge clk);
      #1;
      if (i == abort) begin
        reset = 1'b0;
        return;
      end
    end
  endtask
  initial begin
    logic [5:0] legal [6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
    logic [5:0] fset [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    logic [5:0] o, f;
    int hs [6] = '{0, 1, 12, 12, 12, 12};
    int ns [6] = '{0, 1, 0, 1, 0, 1};
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_state", 16'(state), 16'd0);
      chk("reset_out", obs, 16'h0044);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(6'h23, 6'h00, -1, -1);
    run(6'h04, 6'h00, 1, -1);
    run(6'h04, 6'h00, 0, -1);
    foreach (fset[i]) run(6'h00, fset[i], -1, -1);
    run(6'h08, 6'h00, -1, -1);
    run(6'h3f, 6'h00, -1, -1);
    run(6'h2b, 6'h00, -1, 3);
    run(6'h02, 6'h00, -1, -1);
    repeat (60) begin
      int k = $urandom_range(0, 6);
      if (k < 6) o = legal[k];
      else begin
        o = 6'($urandom);
        while (o inside {legal}) o = 6'($urandom);
      end
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fset[$urandom_range(0, 4)];
      run(o, f, -1, int'($urandom_range(0, 19)) - 18);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    op = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      zero = 1'($urandom);
      @(negedge clk);
      chk("trap_state", 16'(state_t), 16'(hs[i]));
      chk("trap_out", obs_t, ev(hs[i], op, zero));
      chk("nop_state", 16'(state), 16'(ns[i]));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("trap_reset_out", obs_t, 16'h0044);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("trap_reset_state", 16'(state_t), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
